oam_dma: RTL and testbench
==========================

# oam_dma

Sprite-attribute DMA controller for the CPU bus. A CPU write to $4014 arms it with a source page; it then stalls the core through its ready input, takes ownership of the CPU bus, and copies 256 bytes from `{page, 8'h00..8'hFF}` to the PPU OAM data port at $2004 as alternating read/write bus cycles. It sits between the core and the address decoder/data mux in the top level, muxing its address, rdwr and write data over the core's whenever `O_active` is high.

## Interface
- No parameters. Fixed sizes: 8-bit page, 256-byte transfer, target address 16'h2004.
- I_clock  in  1  system clock.
- I_reset  in  1  asynchronous, active-high reset.
- I_tick  in  1  one-clock pulse marking the end of each CPU bus cycle. All state changes happen only on `I_clock` edges where `I_tick`=1.
- I_cpu_rdwr  in  1  core's rdwr for the current cycle (1 = read).
- I_reg_wren  in  1  qualified core write to $4014, already decoded by the parent.
- I_reg_data  in  8  source page written to $4014.
- I_rd_data  in  8  CPU data bus return from the decoder mux.
- O_ready  out  1  to the core's I_ready; 0 stalls the core.
- O_active  out  1  DMA owns the bus; the parent selects O_addr/O_rdwr/O_wr_data.
- O_addr  out  16  DMA bus address.
- O_rdwr  out  1  1 = read, 0 = write.
- O_wr_data  out  8  byte being written to $2004.

## Operation
- Registers:
  - `page` (8 bits) and `idx` (8 bits).
  - `latch` (8 bits).
  - `parity` (1 bit), toggled on every `I_tick` from reset. 0 = get cycle, 1 = put cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - `I_reg_wren` captures `page`<=`I_reg_data` and `idx`<=0, then goes to HALT.
  - It is sampled on any clock, not only on tick clocks.
- HALT:
  - On a tick with `I_cpu_rdwr`=1 (the core's read is stalled): go to READ if the next cycle is a get (`parity`=1 now), otherwise go to ALIGN.
  - On a tick with `I_cpu_rdwr`=0: stay in HALT. The core finishes its write cycle because the 6502 ignores RDY on writes.
- ALIGN: one dummy tick, then READ.
- READ:
  - Drive `O_addr`={`page`,`idx`}, `O_rdwr`=1.
  - On the tick, `latch`<=`I_rd_data`, then go to WRITE.
- WRITE:
  - Drive `O_addr`=16'h2004, `O_rdwr`=0, `O_wr_data`=`latch`.
  - On the tick, `idx`<=`idx`+1 (8-bit wrap).
  - Go to IDLE if `idx` was 8'hFF, otherwise go to READ.
- `I_reg_wren` while not in IDLE is ignored. The transfer is not restarted and `page` is unchanged.
- A page of 8'h20–8'h3F is legal: the bus reads PPU registers with side effects. No special handling.

## Timing
- Reset values:
  - `O_ready`=1, `O_active`=0, `O_addr`=16'h0000, `O_rdwr`=1, `O_wr_data`=8'h00.
  - State=IDLE, `parity`=0, `idx`=0, `page`=0.
- Outputs are registered and take their new value on the clock edge of the transition.
- `O_ready` falls on the edge that leaves IDLE and rises on the edge that returns to IDLE.
- `O_active`=1 in READ and WRITE only. HALT and ALIGN leave the core's own address on the bus.
- Duration from the first tick in HALT to the return to IDLE, with no core write cycles:
  - 513 ticks with no ALIGN.
  - 514 ticks with ALIGN.
  - Each core write cycle seen in HALT adds 1 tick.
- Bus sequence: READ/WRITE pairs strictly alternate. Reads always fall on get cycles and writes on put cycles.
- Reset asserted mid-transfer forces IDLE and `O_ready`=1 immediately (asynchronous). The partial transfer is abandoned.

## Structure
- Shared package:
  - `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE).
  - `C_OAMDATA_ADDR`=16'h2004.
  - `C_OAMDMA_ADDR`=16'h4014 for the parent's decoder.
- Single module, no sub-module. The top level gains a 2:1 mux on addr/rdwr/wr_data keyed by `O_active`; that mux is not part of this block.

## Test plan
- Page 8'h02 written with the next tick a get cycle (ALIGN skipped), `I_cpu_rdwr`=1 at HALT, memory byte k = k^8'hA5:
  - 513 ticks with `O_ready`=0.
  - Writes to 16'h2004 carry 8'hA5, 8'hA4, … in order, 256 of them.
  - Reads hit 16'h0200..16'h02FF.
- Same transfer armed so that ALIGN is taken: exactly 514 ticks; first READ address 16'h0200.
- Core in a write cycle when HALT is entered, for 2 ticks: HALT holds 2 extra ticks and `O_active` stays 0 throughout.
- `I_reg_wren` with page 8'h07 during idx 8'h40: ignored; reads continue at 16'h0241.
- `I_reg_wren` with page 8'h03, then `I_reset` pulsed at idx 8'h80 during WRITE:
  - `O_ready`=1, `O_active`=0 asynchronously.
  - A new write of page 8'h03 restarts at 16'h0300.
- Page 8'hFF: last read at 16'hFFFF; `idx` wraps to 0 and the block returns to IDLE with no address overflow.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared types and bus addresses for the sprite-attribute DMA controller.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } dma_state_t;

  localparam logic [15:0] C_OAMDATA_ADDR = 16'h2004;
  localparam logic [15:0] C_OAMDMA_ADDR  = 16'h4014;

  function automatic logic [15:0] src_addr(input logic [7:0] page, input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: stalls the core, then copies {page,00..FF} to $2004 as get/put bus cycle pairs.
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_tick,
  input  logic        I_cpu_rdwr,
  input  logic        I_reg_wren,
  input  logic [7:0]  I_reg_data,
  input  logic [7:0]  I_rd_data,
  output logic        O_ready,
  output logic        O_active,
  output logic [15:0] O_addr,
  output logic        O_rdwr,
  output logic [7:0]  O_wr_data
);

  dma_state_t  state_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  latch_q;
  logic        parity_q;
  logic        ready_q;
  logic        active_q;
  logic [15:0] addr_q;
  logic        rdwr_q;

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      state_q  <= StIdle;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      latch_q  <= 8'h00;
      parity_q <= 1'b0;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      addr_q   <= 16'h0000;
      rdwr_q   <= 1'b1;
    end else begin
      // Free-running get/put phase: 0 = get, 1 = put.
      if (I_tick) begin
        parity_q <= ~parity_q;
      end

      unique case (state_q)
        StIdle: begin
          // Register write is accepted on any clock, tick or not.
          if (I_reg_wren) begin
            page_q  <= I_reg_data;
            idx_q   <= 8'h00;
            ready_q <= 1'b0;
            state_q <= StHalt;
          end
        end

        StHalt: begin
          // A core write cycle ignores RDY, so wait until the core is stalled on a read.
          if (I_tick && I_cpu_rdwr) begin
            if (parity_q) begin
              state_q  <= StRead;
              active_q <= 1'b1;
              addr_q   <= src_addr(page_q, idx_q);
              rdwr_q   <= 1'b1;
            end else begin
              state_q <= StAlign;
            end
          end
        end

        StAlign: begin
          if (I_tick) begin
            state_q  <= StRead;
            active_q <= 1'b1;
            addr_q   <= src_addr(page_q, idx_q);
            rdwr_q   <= 1'b1;
          end
        end

        StRead: begin
          if (I_tick) begin
            latch_q <= I_rd_data;
            addr_q  <= C_OAMDATA_ADDR;
            rdwr_q  <= 1'b0;
            state_q <= StWrite;
          end
        end

        StWrite: begin
          if (I_tick) begin
            idx_q <= idx_q + 8'd1;
            if (idx_q == 8'hFF) begin
              state_q  <= StIdle;
              ready_q  <= 1'b1;
              active_q <= 1'b0;
              addr_q   <= 16'h0000;
              rdwr_q   <= 1'b1;
            end else begin
              state_q <= StRead;
              addr_q  <= src_addr(page_q, idx_q + 8'd1);
              rdwr_q  <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign O_ready   = ready_q;
  assign O_active  = active_q;
  assign O_addr    = addr_q;
  assign O_rdwr    = rdwr_q;
  assign O_wr_data = latch_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: memory byte k at {page,k} holds k^A5, ticks on alternate clocks.
module tb_oam_dma;

  logic        clk;
  logic        I_reset;
  logic        I_tick;
  logic        I_cpu_rdwr;
  logic        I_reg_wren;
  logic [7:0]  I_reg_data;
  logic [7:0]  I_rd_data;
  logic        O_ready;
  logic        O_active;
  logic [15:0] O_addr;
  logic        O_rdwr;
  logic [7:0]  O_wr_data;

  oam_dma dut (
    .I_clock    (clk),
    .I_reset    (I_reset),
    .I_tick     (I_tick),
    .I_cpu_rdwr (I_cpu_rdwr),
    .I_reg_wren (I_reg_wren),
    .I_reg_data (I_reg_data),
    .I_rd_data  (I_rd_data),
    .O_ready    (O_ready),
    .O_active   (O_active),
    .O_addr     (O_addr),
    .O_rdwr     (O_rdwr),
    .O_wr_data  (O_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the transfer seen on the bus.
  logic        parity_m;
  logic [7:0]  exp_page;
  logic [15:0] last_rd;
  logic [15:0] first_rd;
  int          busy_ticks;
  int          rd_cnt;
  int          wr_cnt;
  int          bad_rd;
  int          bad_wr;
  int          bad_par;
  int          bad_act;
  int          halt_wr_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, score the bus cycle that the coming edge ends,
  // and set the tick for that edge.
  task automatic step(input logic tick);
    @(negedge clk);
    I_reg_wren = 1'b0;
    if (tick) begin
      if (!O_ready && halt_wr_left > 0 && !O_active) begin
        I_cpu_rdwr = 1'b0;
        halt_wr_left--;
      end else begin
        I_cpu_rdwr = 1'b1;
      end
      if (!O_ready) busy_ticks++;
      if (O_active && O_rdwr) begin
        if (O_addr !== {exp_page, rd_cnt[7:0]}) bad_rd++;
        if (parity_m !== 1'b0) bad_par++;
        if (rd_cnt == 0) first_rd = O_addr;
        last_rd = O_addr;
        rd_cnt++;
      end else if (O_active && !O_rdwr) begin
        if (O_addr !== 16'h2004 || O_wr_data !== (wr_cnt[7:0] ^ 8'hA5)) bad_wr++;
        if (parity_m !== 1'b1) bad_par++;
        wr_cnt++;
      end
      parity_m = ~parity_m;
    end
    if (!I_cpu_rdwr && O_active) bad_act++;
    I_tick    = tick;
    I_rd_data = O_addr[7:0] ^ 8'hA5;
  endtask

  // mode 0: plain transfer, 1: stray $4014 write at idx 40, 2: reset at idx 80 in WRITE.
  task automatic xfer(input string tag, input logic [7:0] page, input logic want_align,
                      input int core_wr, input int mode, input int exp_ticks);
    logic want_par;
    int   n;
    logic abort;
    logic stray_done;
    want_par   = ~want_align ^ core_wr[0];
    abort      = 1'b0;
    stray_done = 1'b0;
    n          = 0;
    if (parity_m != want_par) step(1'b1);
    step(1'b0);
    busy_ticks = 0; rd_cnt = 0; wr_cnt = 0;
    bad_rd = 0; bad_wr = 0; bad_par = 0; bad_act = 0;
    first_rd = 16'hxxxx; last_rd = 16'hxxxx;
    exp_page = page;
    halt_wr_left = core_wr;
    I_reg_wren = 1'b1;
    I_reg_data = page;
    step(1'b0);  // captured on a non-tick clock
    chk({tag, "_armed_ready"}, O_ready, 1'b0);
    while (!O_ready && n < 3000 && !abort) begin
      step(~n[0]);
      n++;
      if (mode == 1 && !stray_done && O_active && !O_rdwr && wr_cnt == 8'h40) begin
        I_reg_wren = 1'b1;
        I_reg_data = 8'h07;
        stray_done = 1'b1;
      end
      if (mode == 2 && O_active && !O_rdwr && wr_cnt == 8'h80) begin
        #2 I_reset = 1'b1;
        #1;
        chk({tag, "_rst_ready"}, O_ready, 1'b1);
        chk({tag, "_rst_active"}, O_active, 1'b0);
        chk({tag, "_rst_addr"}, O_addr, 16'h0000);
        I_tick = 1'b0;
        @(negedge clk);
        I_reset  = 1'b0;
        parity_m = 1'b0;
        abort    = 1'b1;
      end
    end
    if (mode != 2) begin
      chk({tag, "_done_ready"}, O_ready, 1'b1);
      chk({tag, "_done_active"}, O_active, 1'b0);
      chk({tag, "_ticks"}, busy_ticks, exp_ticks);
      chk({tag, "_reads"}, rd_cnt, 256);
      chk({tag, "_writes"}, wr_cnt, 256);
      chk({tag, "_bad_rd"}, bad_rd, 0);
      chk({tag, "_bad_wr"}, bad_wr, 0);
      chk({tag, "_bad_parity"}, bad_par, 0);
      chk({tag, "_first_rd"}, first_rd, {page, 8'h00});
      chk({tag, "_last_rd"}, last_rd, {page, 8'hFF});
    end
  endtask

  initial begin
    I_reset = 1'b1; I_tick = 1'b0; I_cpu_rdwr = 1'b1;
    I_reg_wren = 1'b0; I_reg_data = 8'h00; I_rd_data = 8'h00;
    parity_m = 1'b0; halt_wr_left = 0; exp_page = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_ready", O_ready, 1'b1);
    chk("reset_active", O_active, 1'b0);
    chk("reset_addr", O_addr, 16'h0000);
    chk("reset_rdwr", O_rdwr, 1'b1);
    chk("reset_wr_data", O_wr_data, 8'h00);
    I_reset = 1'b0;
    step(1'b0);

    xfer("noalign", 8'h02, 1'b0, 0, 0, 513);
    xfer("align", 8'h02, 1'b1, 0, 0, 514);
    xfer("corewr", 8'h02, 1'b0, 2, 0, 515);
    chk("corewr_active_during_write", bad_act, 0);
    xfer("stray", 8'h02, 1'b0, 0, 1, 513);
    xfer("abort", 8'h03, 1'b0, 0, 2, 0);
    chk("abort_idle_ready", O_ready, 1'b1);
    xfer("restart", 8'h03, 1'b0, 0, 0, 513);
    xfer("pageff", 8'hFF, 1'b1, 0, 0, 514);
    step(1'b1);
    chk("pageff_idle_addr", O_addr, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
